// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: walks a PWM compare value toward a target by a fixed step every N PWM periods.
// Optional macro PWM_RAMP_ABORT_EN adds an abort input that cancels a ramp in progress.
module pwm_ramp_ctrl #(
  parameter int WIDTH  = 16,
  parameter int PERIOD = 20000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] target_duty,
  input  logic [WIDTH-1:0] step,
  input  logic [7:0]       periods_per_step,
  input  logic             period_end,
`ifdef PWM_RAMP_ABORT_EN
  input  logic             abort,
`endif
  output logic [WIDTH-1:0] duty_out,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RAMP   = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;
  localparam logic [WIDTH-1:0] MAX_DUTY = WIDTH'(PERIOD);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic [7:0]       nper_q, nper_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // One extra bit keeps cur+stp and cur-stp from wrapping; a borrow means we crossed the target.
  function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] tgt,
                                                   input logic [WIDTH-1:0] stp);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    sum  = {1'b0, cur} + {1'b0, stp};
    diff = {1'b0, cur} - {1'b0, stp};
    if (cur < tgt) begin
      if (sum >= {1'b0, tgt}) step_toward = tgt;
      else                    step_toward = sum[WIDTH-1:0];
    end else begin
      if (diff[WIDTH] || (diff <= {1'b0, tgt})) step_toward = tgt;
      else                                      step_toward = diff[WIDTH-1:0];
    end
  endfunction

  // Next-state and datapath logic for the ramp FSM
  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    step_d   = step_q;
    nper_d   = nper_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          target_d = (target_duty > MAX_DUTY) ? MAX_DUTY : target_duty;
          step_d   = (step == {WIDTH{1'b0}}) ? {{(WIDTH-1){1'b0}}, 1'b1} : step;
          nper_d   = (periods_per_step == 8'd0) ? 8'd1 : periods_per_step;
          cnt_d    = 8'd0;
          busy_d   = 1'b1;
          state_d  = RAMP;
        end else begin
          busy_d   = 1'b0;
        end
      end
      RAMP: begin
`ifdef PWM_RAMP_ABORT_EN
        if (abort) begin
          cnt_d   = 8'd0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else
`endif
        if (duty_q == target_q) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = FINISH;
        end else if (period_end) begin
          // Duty moves only on the period_end that completes N periods
          if (cnt_q == nper_q - 8'd1) begin
            cnt_d  = 8'd0;
            duty_d = step_toward(duty_q, target_q, step_q);
          end else begin
            cnt_d  = cnt_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      FINISH: begin
        busy_d  = 1'b0;
        cnt_d   = 8'd0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        cnt_d   = 8'd0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      duty_q   <= {WIDTH{1'b0}};
      target_q <= {WIDTH{1'b0}};
      step_q   <= {WIDTH{1'b0}};
      nper_q   <= 8'd0;
      cnt_q    <= 8'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      step_q   <= step_d;
      nper_q   <= nper_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign duty_out = duty_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: table of ramps, randomized ramps vs. an arithmetic model,
// plus hand sequences for reset mid-ramp and (with PWM_RAMP_ABORT_EN) abort.
module tb_pwm_ramp_ctrl;
  localparam int PERIOD = 20000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] target_duty;
  logic [15:0] step;
  logic [7:0]  periods_per_step;
  logic        period_end;
`ifdef PWM_RAMP_ABORT_EN
  logic        abort;
`endif
  logic [15:0] duty_out;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;
  int mdl_duty = 0;

  typedef struct {
    int tgt;
    int stp;
    int n;
    bit pe_with_start;
    int exp_final;
    int exp_upd;
  } vec_t;
  vec_t vecs[8];

  pwm_ramp_ctrl #(.WIDTH(16), .PERIOD(PERIOD)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .target_duty      (target_duty),
    .step             (step),
    .periods_per_step (periods_per_step),
    .period_end       (period_end),
`ifdef PWM_RAMP_ABORT_EN
    .abort            (abort),
`endif
    .duty_out         (duty_out),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: one update moves toward the target by s and never passes it.
  function automatic int model_next(input int d, input int t, input int s);
    if (d < t) return (d + s > t) ? t : d + s;
    else       return (d - s < t) ? t : d - s;
  endfunction

  task automatic pulse_pe();
    period_end = 1'b1;
    tick();
    period_end = 1'b0;
  endtask

  task automatic do_start(input int t, input int s, input int n, input bit pe);
    target_duty      = 16'(t);
    step             = 16'(s);
    periods_per_step = 8'(n);
    start            = 1'b1;
    period_end       = pe;
    tick();
    start            = 1'b0;
    period_end       = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic run_ramp(input int t, input int s, input int n, input bit pe,
                          output int fin, output int nupd);
    int ct, cs, cn, dn;
    ct = (t > PERIOD) ? PERIOD : t;
    cs = (s == 0) ? 1 : s;
    cn = (n == 0) ? 1 : n;
    nupd = 0;
    do_start(t, s, n, pe);
    while (mdl_duty != ct) begin
      for (int k = 0; k < cn; k++) begin
        repeat (2) tick();
        if ($urandom_range(0, 3) == 0) begin
          target_duty = 16'($urandom_range(0, 20000));
          step        = 16'($urandom_range(1, 999));
          start       = 1'b1;
          tick();
          start       = 1'b0;
        end
        check("hold_duty", 32'(duty_out), 32'(mdl_duty));
        check("busy_in_ramp", 32'(busy), 32'd1);
        check("no_early_done", 32'(done), 32'd0);
        pulse_pe();
        if (k == cn - 1) begin
          mdl_duty = model_next(mdl_duty, ct, cs);
          nupd++;
        end
        check("duty_after_pe", 32'(duty_out), 32'(mdl_duty));
      end
    end
    dn = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done === 1'b1) begin
        dn++;
        check("busy_with_done", 32'(busy), 32'd0);
        check("done_latency", 32'(i), 32'd0);
      end
    end
    check("done_pulses", 32'(dn), 32'd1);
    check("busy_end", 32'(busy), 32'd0);
    check("duty_final", 32'(duty_out), 32'(mdl_duty));
    fin = int'(duty_out);
  endtask

  initial begin
    int fin, nu;
    rst = 1'b1; start = 1'b0; period_end = 1'b0;
    target_duty = 16'd0; step = 16'd0; periods_per_step = 8'd0;
`ifdef PWM_RAMP_ABORT_EN
    abort = 1'b0;
`endif
    vecs[0] = '{10000, 2500,  1, 1'b0, 10000, 4};
    vecs[1] = '{3000,  4000,  2, 1'b1, 3000,  2};
    vecs[2] = '{19990, 16990, 1, 1'b0, 19990, 1};
    vecs[3] = '{30000, 0,     1, 1'b0, 20000, 10};
    vecs[4] = '{20000, 5,     3, 1'b0, 20000, 0};
    vecs[5] = '{0,     65535, 1, 1'b0, 0,     1};
    vecs[6] = '{19000, 1000,  0, 1'b0, 19000, 19};
    vecs[7] = '{65535, 65535, 1, 1'b0, 20000, 1};

    repeat (3) tick();
    check("reset_duty", 32'(duty_out), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();
    pulse_pe();
    check("idle_pe_duty", 32'(duty_out), 32'd0);
    check("idle_pe_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_ramp(vecs[i].tgt, vecs[i].stp, vecs[i].n, vecs[i].pe_with_start, fin, nu);
      check("vec_final", 32'(fin), 32'(vecs[i].exp_final));
      check("vec_updates", 32'(nu), 32'(vecs[i].exp_upd));
    end

    for (int i = 0; i < 8; i++) begin
      run_ramp(int'($urandom_range(0, 25000)), int'($urandom_range(500, 8000)),
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), fin, nu);
    end

    // Reset in the middle of a ramp
    rst = 1'b1; tick(); rst = 1'b0; tick();
    mdl_duty = 0;
    do_start(10000, 2500, 1, 1'b0);
    pulse_pe();
    pulse_pe();
    check("pre_rst_duty", 32'(duty_out), 32'd5000);
    #2 rst = 1'b1;
    #1;
    check("rst_duty", 32'(duty_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pulse_pe();
      check("post_rst_duty", 32'(duty_out), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_done", 32'(done), 32'd0);
    end

`ifdef PWM_RAMP_ABORT_EN
    do_start(10000, 2500, 1, 1'b0);
    repeat (3) pulse_pe();
    check("pre_abort_duty", 32'(duty_out), 32'd7500);
    abort = 1'b1;
    period_end = 1'b1;
    tick();
    abort = 1'b0;
    period_end = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_duty", 32'(duty_out), 32'd7500);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_no_done", 32'(done), 32'd0);
    end
    pulse_pe();
    check("abort_idle_duty", 32'(duty_out), 32'd7500);
    mdl_duty = 7500;
    run_ramp(8000, 100, 1, 1'b0, fin, nu);
    check("after_abort_updates", 32'(nu), 32'd5);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16: width of all duty/step values.
REQ-002 SHALL have parameter PERIOD, default 20000: PWM period in clocks, which is also the maximum legal duty value.
REQ-003 SHALL have port clk, input, 1: single clock (50 MHz); all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1: request a ramp; sampled only in IDLE.
REQ-006 SHALL have port target_duty, input, WIDTH: ramp end value, latched on an accepted start.
REQ-007 SHALL have port step, input, WIDTH: duty increment per update, latched on an accepted start.
REQ-008 SHALL have port periods_per_step, input, 8: PWM periods between updates, latched on an accepted start.
REQ-009 SHALL have port period_end, input, 1: one-cycle pulse from the PWM generator on its counter wrap.
REQ-010 SHALL have port duty_out, output, WIDTH: compare value driven to the PWM generator.
REQ-011 SHALL have port busy, output, 1: high while a ramp is in progress.
REQ-012 SHALL have port done, output, 1: one-cycle pulse when a ramp completes.

Function
REQ-013 SHALL implement an FSM with states IDLE, RAMP and FINISH.
REQ-014 In IDLE, start=1 SHALL latch the inputs and enter RAMP next cycle with busy=1; start in any other state SHALL be ignored.
REQ-015 Latching SHALL apply these substitutions: target_duty>PERIOD becomes PERIOD; step=0 becomes 1; periods_per_step=0 becomes 1.
REQ-016 In RAMP, an 8-bit period counter SHALL increment only on period_end; on the period_end where count==N-1 it SHALL clear and perform one duty update.
REQ-017 A duty update SHALL move duty_out toward the target by step (up if below, down if above) and SHALL clamp to the target, never overshooting.
REQ-018 The update arithmetic SHALL use WIDTH+1 bits so that neither duty+step nor duty-step wraps; a wrapped result SHALL be treated as overshoot and clamped.
REQ-019 duty_out SHALL be registered and SHALL change only in the cycle after an update period_end, so the generator sees at most one change per period.
REQ-020 When duty_out equals the target, whether after an update or already at start, the FSM SHALL go RAMP->FINISH.
REQ-021 In FINISH the block SHALL assert done for exactly one cycle, drop busy in that same cycle, and return to IDLE.
REQ-022 duty_out SHALL hold its last value in IDLE and FINISH; a new ramp SHALL start from the current duty_out.
REQ-023 A period_end in IDLE or FINISH SHALL have no effect on any counter or output.
REQ-024 If start and period_end coincide in IDLE, only the start SHALL be acted on; period counting SHALL begin at the next period_end.

Reset
REQ-025 rst=1 SHALL immediately force the state to IDLE and set duty_out=0, busy=0, done=0, period counter=0 and all latched registers to 0.
REQ-026 Reset asserted mid-ramp SHALL abandon the ramp with no done pulse; after release the block SHALL wait for a new start.

Configuration
REQ-027 Macro PWM_RAMP_ABORT_EN SHALL, when defined, add input port abort (1 bit).
REQ-028 With PWM_RAMP_ABORT_EN defined, abort=1 in RAMP SHALL return the FSM to IDLE next cycle with busy=0, no done pulse and duty_out frozen; abort in IDLE or FINISH SHALL be ignored; abort SHALL take priority over a coincident update.
REQ-029 Without PWM_RAMP_ABORT_EN, the abort port and its logic SHALL be absent, and a ramp SHALL end only at the target or on reset.

Verification
REQ-030 Reset, then start with target=10000, step=2500, N=1 and period_end every 20000 clk: duty_out SHALL go 2500, 5000, 7500, 10000 on successive periods; done SHALL pulse once; busy SHALL fall with done.
REQ-031 From duty 10000, start with target=3000, step=4000, N=2: duty_out SHALL step to 6000 after 2 periods and to 3000 (clamped) after 4 periods.
REQ-032 Start with target=30000 and step=0: duty_out SHALL step by 1 per period and end at 20000.
REQ-033 Start with target equal to the current duty_out: done SHALL pulse within 3 clk and duty_out SHALL stay unchanged.
REQ-034 Assert rst mid-ramp at duty 5000: duty_out SHALL be 0 and busy 0 immediately, with no done; a second start pulse issued during a ramp SHALL have no effect.
REQ-035 With PWM_RAMP_ABORT_EN defined, abort at duty 7500: busy SHALL be 0 next cycle, duty_out SHALL hold 7500, and done SHALL stay 0.
